// File: rtl/spi_master_sequencer.sv
// SPI master sequencer: baud divisor, SCLK/SS generation and shift-register strobes.
// Optional SPI_SS_GAP_EN inserts a GAP state holding ss high for one half-period after each byte.
module spi_master_sequencer #(
    parameter int CNT_W = 12,
    parameter int NBITS = 8
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       spe,
    input  logic       start,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [2:0] sppr,
    input  logic [2:0] spr,
    output logic       sclk,
    output logic       ss,
    output logic       send_data,
    output logic       receive_data,
    output logic       flag_high,
    output logic       flags_high,
    output logic       flag_low,
    output logic       flags_low,
    output logic       tip,
    output logic       spif
);

    localparam int EW = $clog2(2 * NBITS + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * NBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        XFER,
        DONE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic             sclk_q, sclk_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;

    logic [CNT_W-1:0] h_new;
    logic [CNT_W-1:0] hm1;
    logic [CNT_W-1:0] hm2;
    logic             in_xfer;
    logic             unused_cpha;

    // cpha only matters to the shift register; it is held here for a stable view
    assign unused_cpha = cpha_q;

    assign h_new = (CNT_W'(sppr) + CNT_W'(1)) << ({1'b0, spr} + 4'd1);
    assign hm1   = h_q - CNT_W'(1);
    assign hm2   = h_q - CNT_W'(2);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= CNT_W'(2);
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        unique case (state_q)
            IDLE: begin
                sclk_d = cpol;
                cnt_d  = '0;
                edge_d = '0;
                if (spe && start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sclk_d = cpol;
                if (!spe) begin
                    state_d = IDLE;
                end else begin
                    h_d     = h_new;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!spe) begin
                    state_d = IDLE;
                    sclk_d  = cpol;
                    cnt_d   = '0;
                    edge_d  = '0;
                end else if (cnt_q == hm1) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EW'(1);
                    if (edge_q == LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d = '0;
`ifdef SPI_SS_GAP_EN
                state_d = spe ? GAP : IDLE;
`else
                state_d = IDLE;
`endif
            end
            GAP: begin
                sclk_d = cpol_q;
                if (!spe || cnt_q == hm1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes anticipate the SCLK edge that the counter wrap will produce
    assign in_xfer      = (state_q == XFER);
    assign sclk         = sclk_q;
    assign ss           = ~in_xfer;
    assign send_data    = (state_q == LOAD);
    assign receive_data = (state_q == DONE);
    assign spif         = (state_q == DONE);
    assign tip          = (state_q != IDLE);
    assign flag_low     = in_xfer && (cnt_q == hm1) && sclk_q;
    assign flags_low    = in_xfer && (cnt_q == hm2) && sclk_q;
    assign flag_high    = in_xfer && (cnt_q == hm1) && !sclk_q;
    assign flags_high   = in_xfer && (cnt_q == hm2) && !sclk_q;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Self-checking bench for spi_master_sequencer.
// Expected waveforms come from half-period arithmetic on the programmed divisor.
module tb_spi_master_sequencer;

    localparam int NBITS = 8;
`ifdef SPI_SS_GAP_EN
    localparam logic GAP_EN = 1'b1;
`else
    localparam logic GAP_EN = 1'b0;
`endif

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       spe;
    logic       start;
    logic       cpol;
    logic       cpha;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       sclk;
    logic       ss;
    logic       send_data;
    logic       receive_data;
    logic       flag_high;
    logic       flags_high;
    logic       flag_low;
    logic       flags_low;
    logic       tip;
    logic       spif;

    int checks = 0;
    int errors = 0;

    spi_master_sequencer #(.CNT_W(12), .NBITS(NBITS)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .spe         (spe),
        .start       (start),
        .cpol        (cpol),
        .cpha        (cpha),
        .sppr        (sppr),
        .spr         (spr),
        .sclk        (sclk),
        .ss          (ss),
        .send_data   (send_data),
        .receive_data(receive_data),
        .flag_high   (flag_high),
        .flags_high  (flags_high),
        .flag_low    (flag_low),
        .flags_low   (flags_low),
        .tip         (tip),
        .spif        (spif)
    );

    always #5 PCLK = ~PCLK;

    // {sclk, ss, fh, fsh, fl, fsl, send, recv, tip, spif}
    function automatic logic [9:0] obs();
        return {sclk, ss, flag_high, flags_high, flag_low, flags_low,
                send_data, receive_data, tip, spif};
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_xfer(input logic pol, input logic [2:0] pp,
                           input logic [2:0] rr, input int abort_t,
                           input bit mutate, input bit spam);
        int h;
        int n;
        int p;
        int nfh;
        int nfl;
        logic s;
        logic [9:0] ev;
        h = (int'(pp) + 1) << (int'(rr) + 1);
        n = 2 * NBITS * h;
        cpol = pol;
        sppr = pp;
        spr = rr;
        spe = 1'b1;
        start = 1'b0;
        tick();
        tick();
        ev = {pol, 1'b1, 8'b0};
        checks++;
        if (obs() !== ev) begin
            errors++;
            $display("FAIL idle h=%0d got %b exp %b", h, obs(), ev);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ev = {pol, 1'b1, 4'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs() !== ev) begin
            errors++;
            $display("FAIL load h=%0d got %b exp %b", h, obs(), ev);
        end
        tick();
        nfh = 0;
        nfl = 0;
        for (int i = 0; i < n; i++) begin
            p = i % h;
            s = pol ^ ((i / h) % 2 == 1);
            ev = {s, 1'b0, (p == h - 1) && !s, (p == h - 2) && !s,
                  (p == h - 1) && s, (p == h - 2) && s, 4'b0010};
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL xfer h=%0d i=%0d got %b exp %b", h, i, obs(), ev);
            end
            nfh += int'(flag_high);
            nfl += int'(flag_low);
            start = 1'b0;
            if (spam && i == h + 1) start = 1'b1;
            if (mutate && i == 3 * h) begin
                cpol = ~pol;
                spr = rr ^ 3'd1;
            end
            if (abort_t > 0 && i == abort_t * h) begin
                spe = 1'b0;
                tick();
                ev = {pol, 1'b1, 8'b0};
                checks++;
                if (obs() !== ev) begin
                    errors++;
                    $display("FAIL abort h=%0d got %b exp %b", h, obs(), ev);
                end
                spe = 1'b1;
                tick();
                ev = {pol, 1'b1, 8'b0};
                checks++;
                if (obs() !== ev) begin
                    errors++;
                    $display("FAIL abort_idle h=%0d got %b exp %b", h, obs(), ev);
                end
                return;
            end
            tick();
        end
        checks++;
        if (nfh !== NBITS || nfl !== NBITS) begin
            errors++;
            $display("FAIL flag_count h=%0d got %0d/%0d exp %0d", h, nfh, nfl, NBITS);
        end
        start = spam;
        ev = {pol, 1'b1, 4'b0, 4'b0111};
        checks++;
        if (obs() !== ev) begin
            errors++;
            $display("FAIL done h=%0d got %b exp %b", h, obs(), ev);
        end
        tick();
        start = 1'b0;
        ev = {pol, 1'b1, 4'b0, 2'b00, GAP_EN, 1'b0};
        checks++;
        if (obs() !== ev) begin
            errors++;
            $display("FAIL post_done h=%0d got %b exp %b", h, obs(), ev);
        end
`ifndef SPI_SS_GAP_EN
        tick();
        checks++;
        if (sclk !== cpol || tip !== 1'b0) begin
            errors++;
            $display("FAIL idle_follow h=%0d got %b exp %b", h, sclk, cpol);
        end
`else
        repeat (h + 1) tick();
`endif
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        spe = 1'b0;
        start = 1'b0;
        cpol = 1'b1;
        cpha = 1'b0;
        sppr = 3'd0;
        spr = 3'd0;
        #3;
        checks++;
        if (obs() !== {1'b0, 1'b1, 8'b0}) begin
            errors++;
            $display("FAIL reset got %b exp %b", obs(), {1'b0, 1'b1, 8'b0});
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        checks++;
        if (sclk !== 1'b1 || ss !== 1'b1 || tip !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got sclk=%b ss=%b exp sclk=1 ss=1", sclk, ss);
        end
    endtask

    task automatic test_spe_gate();
        spe = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (send_data !== 1'b0 || tip !== 1'b0) begin
            errors++;
            $display("FAIL spe_gate got send=%b tip=%b exp 0 0", send_data, tip);
        end
        spe = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        cpol = 1'b0;
        sppr = 3'd0;
        spr = 3'd0;
        spe = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2 * NBITS * 2 + 1) tick();
        checks++;
        if (spif !== 1'b1 || ss !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done got spif=%b ss=%b exp 1 1", spif, ss);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (send_data !== ~GAP_EN) begin
            errors++;
            $display("FAIL b2b_start got %b exp %b", send_data, ~GAP_EN);
        end
`ifndef SPI_SS_GAP_EN
        repeat (2 * NBITS * 2 + 1) tick();
        checks++;
        if (spif !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got %b exp 1", spif);
        end
`endif
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        cpol = 1'b1;
        sppr = 3'd1;
        spr = 3'd0;
        spe = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #1;
        PRESETn = 1'b0;
        #1;
        checks++;
        if (obs() !== {1'b0, 1'b1, 8'b0}) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", obs(), {1'b0, 1'b1, 8'b0});
        end
        #1;
        PRESETn = 1'b1;
        tick();
        checks++;
        if (obs() !== {1'b1, 1'b1, 8'b0}) begin
            errors++;
            $display("FAIL async_release got %b exp %b", obs(), {1'b1, 1'b1, 8'b0});
        end
    endtask

    initial begin
        test_reset();
        do_xfer(1'b0, 3'd0, 3'd0, 0, 1'b0, 1'b0);
        do_xfer(1'b1, 3'd2, 3'd1, 0, 1'b0, 1'b0);
        do_xfer(1'b0, 3'd1, 3'd0, 0, 1'b1, 1'b0);
        do_xfer(1'b1, 3'd0, 3'd1, 5, 1'b0, 1'b0);
        do_xfer(1'b1, 3'd0, 3'd1, 0, 1'b0, 1'b0);
        do_xfer(1'b0, 3'd0, 3'd0, 0, 1'b0, 1'b1);
        test_spe_gate();
        test_back_to_back();
        repeat (4) begin
            do_xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                    3'($urandom_range(0, 2)), 0, 1'b0, 1'($urandom_range(0, 1)));
        end
        do_xfer(1'b1, 3'd7, 3'd7, 0, 1'b0, 1'b0);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
